// File: rtl/qspi_flash_rd_seq.sv
// Single-lane SPI (mode 0) read sequencer: CMD + 24-bit address on DQ0, 32 data bits from DQ1.
// Returns one little-endian word per request on a valid/ready response channel.
module qspi_flash_rd_seq #(
    parameter int unsigned DIV    = 2,
    parameter logic [7:0]  RD_CMD = 8'h03
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        sck,
    output logic        cs_n,
    output logic [3:0]  dq_o,
    output logic [3:0]  dq_oe,
    input  logic [3:0]  dq_i
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [5:0] BIT_CMD_LAST  = 6'd7;
    localparam logic [5:0] BIT_ADDR_LAST = 6'd31;
    localparam logic [5:0] BIT_DATA_LAST = 6'd63;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_GAP,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic [30:0]      out_sr_q, out_sr_d;
    logic [31:0]      in_sr_q, in_sr_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic [3:0]       dq_o_q, dq_o_d;
    logic [3:0]       dq_oe_q, dq_oe_d;

    // Only DQ1 carries read data in single-lane mode
    logic unused_dq;
    assign unused_dq = ^{dq_i[3:2], dq_i[0]};

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            out_sr_q    <= '0;
            in_sr_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            dq_o_q      <= '0;
            dq_oe_q     <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            out_sr_q    <= out_sr_d;
            in_sr_q     <= in_sr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        out_sr_d    = out_sr_q;
        in_sr_d     = in_sr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        sck_d       = sck_q;
        cs_n_d      = cs_n_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = dq_oe_q;

        // MISO is captured in the first cycle of each SCK high phase
        if ((state_q == S_DATA) && sck_q && (div_q == '0)) begin
            in_sr_d = {in_sr_q[30:0], dq_i[1]};
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d  = S_CMD;
                    out_sr_d = {RD_CMD[6:0], req_addr};
                    div_d    = '0;
                    bit_d    = '0;
                    sck_d    = 1'b0;
                    cs_n_d   = 1'b0;
                    dq_oe_d  = 4'b1101;
                    dq_o_d   = {2'b11, 1'b0, RD_CMD[7]};
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CNT_W'(1);
                end else begin
                    div_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        bit_d = bit_q + 6'd1;
                        if (bit_q == BIT_DATA_LAST) begin
                            state_d    = S_GAP;
                            cs_n_d     = 1'b1;
                            dq_o_d     = '0;
                            dq_oe_d    = '0;
                            rsp_data_d = {in_sr_d[7:0], in_sr_d[15:8],
                                          in_sr_d[23:16], in_sr_d[31:24]};
                        end else begin
                            if (bit_q == BIT_CMD_LAST) begin
                                state_d = S_ADDR;
                            end else if (bit_q == BIT_ADDR_LAST) begin
                                state_d = S_DATA;
                            end
                            // DQ0 is released once the address has been sent
                            if ((bit_q == BIT_ADDR_LAST) || (state_q == S_DATA)) begin
                                dq_oe_d[0] = 1'b0;
                                dq_o_d[0]  = 1'b0;
                            end else begin
                                dq_o_d[0] = out_sr_q[30];
                                out_sr_d  = {out_sr_q[29:0], 1'b0};
                            end
                        end
                    end
                end
            end
            S_GAP: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + CNT_W'(1);
                end else begin
                    div_d       = '0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign sck       = sck_q;
    assign cs_n      = cs_n_q;
    assign dq_o      = dq_o_q;
    assign dq_oe     = dq_oe_q;

endmodule

// File: tb/tb_qspi_flash_rd_seq.sv
// Bench for qspi_flash_rd_seq: DIV=2 and DIV=1 instances, a byte-level flash model driving MISO,
// a frame monitor checking SPI timing and the transmitted command/address, and response checks.
module tb_qspi_flash_rd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [23:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        busy      [2];
    logic        sck       [2];
    logic        cs_n      [2];
    logic [3:0]  dq_o      [2];
    logic [3:0]  dq_oe     [2];
    logic [3:0]  dq_i      [2];

    qspi_flash_rd_seq #(.DIV(2), .RD_CMD(8'h03)) u_div2 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]), .sck(sck[0]), .cs_n(cs_n[0]),
        .dq_o(dq_o[0]), .dq_oe(dq_oe[0]), .dq_i(dq_i[0])
    );

    qspi_flash_rd_seq #(.DIV(1), .RD_CMD(8'h03)) u_div1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]), .sck(sck[1]), .cs_n(cs_n[1]),
        .dq_o(dq_o[1]), .dq_oe(dq_oe[1]), .dq_i(dq_i[1])
    );

    typedef struct {
        logic [23:0] addr;
        logic [7:0]  b0, b1, b2, b3;
        int          stall;
        bit          hold;
        logic [23:0] nxt;
        logic [31:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Flash model contents and per-instance monitor state
    logic [7:0]  fbytes    [2][4];
    bit          tie1      [2];
    logic [23:0] addr_log  [2][64];
    int          wr_idx    [2];
    int          rd_idx    [2];
    bit          prev_cs   [2];
    bit          prev_sck  [2];
    bit          prev_dq0  [2];
    bit          seen_frame[2];
    int          run_len   [2];
    int          cs_len    [2];
    int          nbits     [2];
    logic [31:0] mosi      [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic vec_t mk(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input int st,
                                input bit h, input logic [23:0] n, input logic [31:0] e);
        vec_t v;
        v.addr = a; v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
        v.stall = st; v.hold = h; v.nxt = n; v.exp = e;
        return v;
    endfunction

    // Bit b of the frame as the flash drives it: don't-care during CMD/ADDR, then bytes MSB first
    function automatic logic miso_bit(input int i, input int b);
        int j;
        logic [7:0] byt;
        if (tie1[i]) return 1'b1;
        if (b < 32) return 1'($urandom_range(0, 1));
        j = b - 32;
        byt = fbytes[i][j / 8];
        return byt[7 - (j % 8)];
    endfunction

    task automatic monitor_step(input int i);
        int d;
        logic [23:0] ea;
        d = div_of(i);
        if (!rst_n[i]) begin
            rd_idx[i] = wr_idx[i];
            prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_dq0[i] = 1'b0;
            run_len[i] = 0; cs_len[i] = 0; nbits[i] = 0; seen_frame[i] = 1'b0;
            dq_i[i] = 4'h0;
            return;
        end
        if (!cs_n[i]) chk("pads_hold", {28'h0, dq_oe[i][3:2], dq_o[i][3:2]}, 32'hF);
        chk("dq_idle", {30'h0, dq_oe[i][1], ~dq_oe[i][0] & dq_o[i][0]}, 32'h0);
        if (cs_n[i]) chk("sck_idle", 32'(sck[i]), 32'h0);
        if (prev_cs[i] && !cs_n[i]) begin
            if (seen_frame[i]) chk("cs_gap_min", 32'(cs_len[i] >= d + 2), 32'h1);
            cs_len[i] = 1; run_len[i] = 1; nbits[i] = 0; mosi[i] = '0;
            dq_i[i] = {2'b00, miso_bit(i, 0), 1'b0};
        end else if (!prev_cs[i] && cs_n[i]) begin
            chk("frame_end", {28'h0, nbits[i] == 64, cs_len[i] == 128 * d, prev_sck[i],
                              run_len[i] == d}, 32'hF);
            chk("addr_queued", 32'(rd_idx[i] < wr_idx[i]), 32'h1);
            ea = (rd_idx[i] < wr_idx[i]) ? addr_log[i][rd_idx[i]] : 24'h0;
            rd_idx[i]++;
            chk("mosi_frame", mosi[i], {8'h03, ea});
            seen_frame[i] = 1'b1;
            cs_len[i] = 1;
        end else if (!cs_n[i]) begin
            cs_len[i]++;
            if (dq_o[i][0] != prev_dq0[i])
                chk("dq0_on_fall", 32'(!sck[i] && prev_sck[i]), 32'h1);
            if (sck[i] != prev_sck[i]) begin
                chk("sck_half", 32'(run_len[i]), 32'(d));
                run_len[i] = 1;
                if (sck[i]) begin
                    if (nbits[i] < 32) mosi[i] = {mosi[i][30:0], dq_o[i][0]};
                    nbits[i]++;
                end else begin
                    dq_i[i] = {2'b00, miso_bit(i, nbits[i]), 1'b0};
                end
            end else begin
                run_len[i]++;
            end
        end else begin
            cs_len[i]++;
        end
        prev_cs[i] = cs_n[i];
        prev_sck[i] = sck[i];
        prev_dq0[i] = dq_o[i][0];
    endtask

    // One read: request, latency from accept, response data, optional back-pressure
    task automatic do_read(input int i, input vec_t v);
        int k;
        int lat;
        int d;
        d = div_of(i);
        fbytes[i][0] = v.b0; fbytes[i][1] = v.b1; fbytes[i][2] = v.b2; fbytes[i][3] = v.b3;
        addr_log[i][wr_idx[i]] = v.addr;
        wr_idx[i]++;
        req_valid[i] = 1'b1;
        req_addr[i] = v.addr;
        k = 0;
        while (!req_ready[i] && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready[i]) begin
            chk("accept_timeout", 32'h0, 32'h1);
            req_valid[i] = 1'b0;
            return;
        end
        @(negedge clk);
        lat = 1;
        if (v.hold) req_addr[i] = v.nxt;
        else req_valid[i] = 1'b0;
        chk("accepted", {29'h0, req_ready[i], cs_n[i], busy[i]}, 32'h1);
        while (!rsp_valid[i] && lat < 140 * d) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", 32'(lat), 32'(129 * d + 1));
        chk("rsp_data", rsp_data[i], v.exp);
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk("stall_hold", {28'h0, rsp_valid[i], req_ready[i], cs_n[i], busy[i]}, 32'hB);
            chk("stall_data", rsp_data[i], v.exp);
        end
        rsp_ready[i] = 1'b1;
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        chk("rsp_done", {29'h0, rsp_valid[i], req_ready[i], busy[i]}, 32'h2);
    endtask

    task automatic run_random(input int i, input int n);
        vec_t rv[8];
        logic [7:0] b0, b1, b2, b3;
        for (int k = 0; k < n; k++) begin
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            rv[k] = mk(24'($urandom), b0, b1, b2, b3, int'($urandom_range(0, 3)), 1'b0, 24'h0,
                       {b3, b2, b1, b0});
        end
        for (int k = 0; k < n - 1; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                rv[k].hold = 1'b1;
                rv[k].nxt = rv[k + 1].addr;
            end
        end
        for (int k = 0; k < n; k++) do_read(i, rv[k]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        int k;
        int lat;

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = '0; rsp_ready[i] = 1'b0;
            dq_i[i] = 4'h0; tie1[i] = 1'b0; wr_idx[i] = 0; rd_idx[i] = 0;
        end

        fork
            forever begin
                @(posedge clk);
                #2;
                monitor_step(0);
                monitor_step(1);
            end
        join_none

        // Reset values, then ready one cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctl", {27'h0, req_ready[i], rsp_valid[i], busy[i], sck[i], cs_n[i]}, 32'h1);
            chk("reset_pads", {24'h0, dq_o[i], dq_oe[i]}, 32'h0);
            chk("reset_data", rsp_data[i], 32'h0);
            rst_n[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("ready_after_reset", {29'h0, req_ready[i], cs_n[i], sck[i]}, 32'h6);

        // DIV=2 vectors: basic read, back-pressure with held request, back-to-back pair
        tbl[0] = mk(24'h000100, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 0, 1'b0, 24'h0, 32'hDEADBEEF);
        tbl[1] = mk(24'h000100, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 10, 1'b1, 24'h000200, 32'hDEADBEEF);
        tbl[2] = mk(24'h000200, 8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0, 24'h0, 32'h44332211);
        tbl[3] = mk(24'h000000, 8'h01, 8'h02, 8'h03, 8'h04, 0, 1'b1, 24'h000004, 32'h04030201);
        tbl[4] = mk(24'h000004, 8'hA5, 8'h5A, 8'h00, 8'hFF, 0, 1'b0, 24'h0, 32'hFF005AA5);
        for (int t = 0; t < 5; t++) do_read(0, tbl[t]);

        // Reset pulse during address bit 10 abandons the frame
        addr_log[0][wr_idx[0]] = 24'h123456;
        wr_idx[0]++;
        req_valid[0] = 1'b1;
        req_addr[0] = 24'h123456;
        k = 0;
        while (!req_ready[0] && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort_accept", 32'(req_ready[0]), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        lat = 1;
        while (lat < 1 + 36 * 2 + 1) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_in_frame", {30'h0, cs_n[0], busy[0]}, 32'h1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("abort_ctl", {27'h0, req_ready[0], rsp_valid[0], busy[0], sck[0], cs_n[0]}, 32'h1);
        chk("abort_pads", {24'h0, dq_o[0], dq_oe[0]}, 32'h0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(req_ready[0]), 32'h1);
        repeat (5) begin
            @(negedge clk);
            chk("abort_no_rsp", {30'h0, rsp_valid[0], cs_n[0]}, 32'h1);
        end
        do_read(0, mk(24'h000010, 8'h12, 8'h34, 8'h56, 8'h78, 0, 1'b0, 24'h0, 32'h78563412));

        run_random(0, 6);

        // DIV=1 with MISO tied high
        tie1[1] = 1'b1;
        do_read(1, mk(24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 24'h0, 32'hFFFFFFFF));
        tie1[1] = 1'b0;
        run_random(1, 4);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
